// File: rtl/lsb_serial_deserializer.sv
// lsb_serial_deserializer: packs an LSB-first bit stream into WIDTH-bit words and buffers them in a DEPTH-entry FIFO with a valid/ready output and sticky overflow. Ports: clk, areset (async, active-high), sync_clr, bit_in, bit_valid, out_data, out_valid, out_ready, fifo_level, overflow.
module lsb_serial_deserializer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     sync_clr,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    wp, rp;
  logic             done, pop, push;
  always_comb begin
    word = {bit_in, acc};
    done = bit_valid && !sync_clr && cnt == CW'(WIDTH - 1);
    pop  = out_valid && out_ready;
    push = done && (fifo_level != LW'(DEPTH) || pop);
  end
  assign out_valid = fifo_level != '0;
  assign out_data  = mem[rp];
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      acc        <= '0;
      cnt        <= '0;
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (sync_clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (bit_valid) begin
        acc <= word[WIDTH-1:1];
        cnt <= done ? '0 : cnt + CW'(1);
      end
      overflow <= sync_clr ? 1'b0 : overflow | (done & !push);
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= word;
endmodule

// File: tb/tb_lsb_serial_deserializer.sv
// tb_lsb_serial_deserializer: table vectors, hand-written corner sequences and random stimulus against a queue-based model.
module tb_lsb_serial_deserializer;
  localparam int W = 4;
  localparam int D = 2;
  logic clk = 1'b0, areset = 1'b0, sync_clr = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic out_valid, overflow;
  logic [$clog2(D):0] fifo_level;
  int nchk = 0, nerr = 0;
  logic [W-1:0] q[$];
  int mv = 0, mn = 0;
  bit mov = 1'b0;
  typedef struct {
    bit bv, b, rdy, clr, ev;
    int ed, el;
    bit eo;
  } vec_t;
  vec_t tv[$];

  lsb_serial_deserializer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .areset(areset), .sync_clr(sync_clr), .bit_in(bit_in), .bit_valid(bit_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic void chk(string n, int a, int e);
    nchk++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    mv = 0;
    mn = 0;
    mov = 1'b0;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #2 areset = 1'b1;
    #2 areset = 1'b0;
    model_reset();
    #2;
  endtask

  task automatic step(input bit bv, input bit b, input bit rdy, input bit clr);
    bit_valid = bv;
    bit_in = b;
    out_ready = rdy;
    sync_clr = clr;
    @(posedge clk);
    #1;
    if (q.size() > 0 && rdy) void'(q.pop_front());
    if (clr) begin
      mv = 0;
      mn = 0;
      mov = 1'b0;
    end else if (bv) begin
      mv = mv + (int'(b) << mn);
      mn++;
      if (mn == W) begin
        if (q.size() < D) q.push_back(W'(mv));
        else mov = 1'b1;
        mv = 0;
        mn = 0;
      end
    end
    chk("m_valid", int'(out_valid), int'(q.size() > 0));
    chk("m_level", int'(fifo_level), q.size());
    chk("m_overflow", int'(overflow), int'(mov));
    if (q.size() > 0) chk("m_data", int'(out_data), int'(q[0]));
  endtask

  task automatic send(input int w, input bit rdy);
    for (int i = 0; i < W; i++) step(1'b1, w[i], rdy, 1'b0);
  endtask

  task automatic add(input bit bv, b, rdy, clr, ev, input int ed, el, input bit eo);
    vec_t v;
    v.bv = bv; v.b = b; v.rdy = rdy; v.clr = clr; v.ev = ev; v.ed = ed; v.el = el; v.eo = eo;
    tv.push_back(v);
  endtask

  initial begin
    add(1,1,1,0, 0,0,0,0); add(1,0,1,0, 0,0,0,0); add(1,1,1,0, 0,0,0,0); add(1,1,1,0, 1,'hD,1,0);
    add(0,0,1,0, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0); add(1,1,0,0, 0,0,0,0); add(1,0,0,0, 0,0,0,0); add(1,1,0,0, 1,'hA,1,0);
    add(1,1,0,0, 1,'hA,1,0); add(1,0,0,0, 1,'hA,1,0); add(1,1,0,0, 1,'hA,1,0); add(1,0,0,0, 1,'hA,2,0);
    add(1,1,0,0, 1,'hA,2,0); add(1,1,0,0, 1,'hA,2,0); add(1,1,0,0, 1,'hA,2,0); add(1,1,0,0, 1,'hA,2,1);
    add(0,0,1,0, 1,'h5,1,1); add(0,0,1,0, 0,0,0,1); add(0,0,0,1, 0,0,0,0);

    do_reset();
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_level", int'(fifo_level), 0);
    chk("reset_overflow", int'(overflow), 0);
    foreach (tv[i]) begin
      step(tv[i].bv, tv[i].b, tv[i].rdy, tv[i].clr);
      chk($sformatf("tv%0d_valid", i), int'(out_valid), int'(tv[i].ev));
      chk($sformatf("tv%0d_level", i), int'(fifo_level), tv[i].el);
      chk($sformatf("tv%0d_overflow", i), int'(overflow), int'(tv[i].eo));
      if (tv[i].ev) chk($sformatf("tv%0d_data", i), int'(out_data), tv[i].ed);
    end

    do_reset();
    for (int i = 0; i < W; i++) begin
      for (int g = 0; g < 2 + (i % 2); g++) begin
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("gap_no_valid", int'(out_valid), 0);
      end
      step(1'b1, (i == 1 || i == 2), 1'b0, 1'b0);
      chk("gap_valid", int'(out_valid), int'(i == W - 1));
    end
    chk("gap_data", int'(out_data), 'h6);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("gap_drained", int'(fifo_level), 0);

    do_reset();
    send('h1, 1'b0);
    send('h2, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("pp_overflow", int'(overflow), 0);
    chk("pp_level", int'(fifo_level), 2);
    chk("pp_head", int'(out_data), 'h2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pp_second", int'(out_data), 'h3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pp_empty", int'(out_valid), 0);

    do_reset();
    send('h9, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    send('h8, 1'b0);
    chk("clr_level", int'(fifo_level), 2);
    chk("clr_head", int'(out_data), 'h9);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_word", int'(out_data), 'h8);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    do_reset();
    send('hC, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    #2 areset = 1'b1;
    #1;
    chk("ar_valid", int'(out_valid), 0);
    chk("ar_level", int'(fifo_level), 0);
    chk("ar_overflow", int'(overflow), 0);
    #1 areset = 1'b0;
    model_reset();
    send('hF, 1'b0);
    chk("ar_word", int'(out_data), 'hF);
    chk("ar_one", int'(fifo_level), 1);

    do_reset();
    for (int i = 0; i < 600; i++)
      step($urandom_range(9) < 6, $urandom_range(1), $urandom_range(1), $urandom_range(19) == 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/lsb_serial_deserializer.md
Name: lsb_serial_deserializer

Overview:
Sits directly downstream of the right-shifting serializer. It consumes that serializer's LSB-first bit stream (its q[0] output, qualified by the same enable) and reassembles the bits into WIDTH-bit words. Completed words are buffered in a small FIFO and presented on a valid/ready output interface, with sticky overflow detection when a word arrives while the FIFO is full.

Parameters:
WIDTH, 4, word width in bits (bits per frame); must be >= 2.
DEPTH, 2, output FIFO entries; power of 2, >= 2.

Ports:
clk  in  1  clock; all state updates on posedge.
areset  in  1  asynchronous, active-high reset; clears all state.
sync_clr  in  1  synchronous clear of the partial word and of overflow; FIFO untouched.
bit_in  in  1  serial data bit, LSB of each word first.
bit_valid  in  1  bit_in is sampled on this edge.
out_data  out  WIDTH  head-of-FIFO word.
out_valid  out  1  FIFO non-empty.
out_ready  in  1  consumer accepts out_data this cycle.
fifo_level  out  $clog2(DEPTH)+1  number of words held, 0..DEPTH.
overflow  out  1  sticky; a completed word was dropped.

Behaviour:
- Reset (areset=1, async): accumulator=0, bit_cnt=0, FIFO pointers=0, fifo_level=0, out_valid=0, overflow=0. out_data is a don't-care while out_valid=0; the bench must not check it.
- Accumulator: on edge with bit_valid=1 and sync_clr=0: acc <= {bit_in, acc[WIDTH-1:1]}; bit_cnt increments.
  - First bit received lands in bit 0 of the completed word.
  - bit_valid=0: acc and bit_cnt hold; gaps of any length allowed.
- Word completion: edge with bit_valid=1 and bit_cnt==WIDTH-1.
  - word = {bit_in, acc[WIDTH-1:1]}; bit_cnt wraps to 0.
  - A push is requested the same edge.
- Push rules:
  - Accepted if fifo_level<DEPTH, or if fifo_level==DEPTH and a pop occurs the same edge (pop-then-push; level unchanged).
  - Otherwise the word is dropped, FIFO unchanged, overflow <= 1.
- Pop: edge with out_valid=1 and out_ready=1; head advances. out_ready while empty has no effect.
- Simultaneous push+pop at any level: level unchanged, ordering preserved.
- Latency: out_valid rises on the cycle after the edge that samples the last bit (empty FIFO). There is no combinational bypass from bit_in to out_data.
- out_data = mem[rd_ptr]; stable while out_valid=1 and out_ready=0.
- sync_clr=1 (priority over bit_valid):
  - acc<=0, bit_cnt<=0, overflow<=0; bit_in that cycle is discarded.
  - FIFO contents, level, and a same-cycle pop are unaffected.
- Pointers wrap modulo DEPTH. fifo_level and out_valid are registered (derived from state, no input-to-output combinational path).
- areset mid-word or mid-drain discards the partial word and all buffered words; first post-reset bit is bit 0 of a new word.

Test Plan:
All scenarios use WIDTH=4, DEPTH=2.
1. Basic word: areset pulse; out_ready=1; bits 1,0,1,1 on 4 consecutive bit_valid cycles -> out_valid=1 exactly one cycle (the cycle after the 4th edge), out_data=4'hD, fifo_level returns to 0, overflow=0.
2. Gapped input: bits 0,1,1,0 with 2-3 idle cycles between each -> single word 4'h6; no out_valid before the 4th bit's edge.
3. Full and overflow: out_ready=0; send words 0xA, 0x5, 0xF -> fifo_level=2 after the 2nd, overflow=1 after the 3rd. Then out_ready=1 -> 0xA then 0x5 on consecutive cycles, level=0, overflow stays 1 until sync_clr.
4. Push on full with pop: FIFO holds 0x1, 0x2; the 4th bit of 0x3 coincides with a pop -> overflow=0, level stays 2, drained order 0x2, 0x3.
5. sync_clr mid-word: bits 1,1, then sync_clr (with bit_valid=1), then bits 0,0,0,1 -> one word 4'h8. Buffered words before sync_clr are still delivered.
6. Async reset mid-operation: FIFO holds 0xC, plus 2 bits of the next word; assert areset between edges -> out_valid, fifo_level, overflow go to 0 immediately. Next 4 bits 1,1,1,1 -> 4'hF.
